// File: rtl/ysyx_23060184_clint.sv
// CLINT timer: free-running 64-bit mtime behind a prescaler, exposed as two
// 32-bit words through an AXI4-Lite slave with independent read and write paths.
module ysyx_23060184_clint #(
    parameter logic [31:0] CLINT_ADDR_BEGIN = 32'h0200_0000,
    parameter logic [31:0] CLINT_ADDR_END   = 32'h0200_FFFF,
    parameter int unsigned DIV              = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned   PW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX        = PW'(DIV - 1);
    localparam logic [31:0]   OFF_LO      = 32'h0000_BFF8;
    localparam logic [31:0]   OFF_HI      = 32'h0000_BFFC;
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [1:0]    RESP_DECERR = 2'b11;

    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    function automatic logic [1:0] addr_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - CLINT_ADDR_BEGIN;
        if (addr < CLINT_ADDR_BEGIN || addr > CLINT_ADDR_END) return RESP_DECERR;
        if (off == OFF_LO || off == OFF_HI) return RESP_OKAY;
        return RESP_SLVERR;
    endfunction

    logic [63:0]   mtime_q, mtime_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick;
    logic          live_q;

    r_state_e      r_state_q, r_state_d;
    logic [31:0]   rdata_d;
    logic [1:0]    rresp_d;
    logic          ar_hs;

    w_state_e      w_state_q, w_state_d;
    logic          aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    bresp_d;
    logic          aw_hs, w_hs, aw_have, w_have, do_write, wr_hi;
    logic [31:0]   wr_addr, wr_data, wr_word;
    logic [3:0]    wr_strb;
    logic [1:0]    wr_resp;

    // live_q keeps the ready signals low until the first edge after reset release.
    assign tick    = (pcnt_q == PMAX);
    assign arready = live_q && (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign awready = live_q && !aw_got_q && (w_state_q != W_RESP);
    assign wready  = live_q && !w_got_q && (w_state_q != W_RESP);
    assign bvalid  = (w_state_q == W_RESP);
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata;
        rresp_d   = rresp;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rresp_d   = addr_resp(araddr);
                    if (rresp_d != RESP_OKAY) begin
                        rdata_d = '0;
                    end else if ((araddr - CLINT_ADDR_BEGIN) == OFF_HI) begin
                        rdata_d = mtime_q[63:32];
                    end else begin
                        rdata_d = mtime_q[31:0];
                    end
                end
            end
            R_DATA: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        aw_have   = aw_got_q || aw_hs;
        w_have    = w_got_q || w_hs;
        do_write  = (w_state_q != W_RESP) && aw_have && w_have;
        wr_addr   = aw_got_q ? awaddr_q : awaddr;
        wr_data   = w_got_q ? wdata_q : wdata;
        wr_strb   = w_got_q ? wstrb_q : wstrb;
        wr_resp   = addr_resp(wr_addr);
        wr_hi     = (wr_addr - CLINT_ADDR_BEGIN) == OFF_HI;
        aw_got_d  = aw_have && !do_write;
        w_got_d   = w_have && !do_write;
        awaddr_d  = aw_hs ? awaddr : awaddr_q;
        wdata_d   = w_hs ? wdata : wdata_q;
        wstrb_d   = w_hs ? wstrb : wstrb_q;
        bresp_d   = bresp;
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE, W_WAIT: begin
                if (do_write) begin
                    w_state_d = W_RESP;
                    bresp_d   = wr_resp;
                end else if (aw_have || w_have) begin
                    w_state_d = W_WAIT;
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
        mtime_d = mtime_q + 64'(tick);
        wr_word = wr_hi ? mtime_q[63:32] : mtime_q[31:0];
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) wr_word[8*i +: 8] = wr_data[8*i +: 8];
        end
        // A committed write overrides the whole value; a coincident tick is dropped.
        if (do_write && wr_resp == RESP_OKAY) begin
            if (wr_hi) mtime_d = {wr_word, mtime_q[31:0]};
            else       mtime_d = {mtime_q[63:32], wr_word};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime_q   <= '0;
            pcnt_q    <= '0;
            live_q    <= 1'b0;
            r_state_q <= R_IDLE;
            rdata     <= '0;
            rresp     <= '0;
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp     <= '0;
        end else begin
            mtime_q   <= mtime_d;
            pcnt_q    <= pcnt_d;
            live_q    <= 1'b1;
            r_state_q <= r_state_d;
            rdata     <= rdata_d;
            rresp     <= rresp_d;
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp     <= bresp_d;
        end
    end

endmodule
